// File: rtl/laa_pkg.sv
// Shared types and constants for the LAA dispatcher.
//   laa_opcode_t  : operation code driven on laa_op toward the accelerator
//   disp_state_t  : dispatcher sequencing states
//   LAA_CUSTOM_OPCODE / FUNCT_* : custom-0 instruction decode constants
package laa_pkg;

  typedef enum logic [1:0] {
    LAA_NONE     = 2'd0,
    LAA_READ     = 2'd1,
    LAA_WRITE    = 2'd2,
    LAA_MULTIPLY = 2'd3
  } laa_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_POLL  = 2'd2,
    ST_WB    = 2'd3
  } disp_state_t;

  localparam logic [6:0] LAA_CUSTOM_OPCODE = 7'b0001011;
  localparam logic [4:0] FUNCT_READ        = 5'd1;
  localparam logic [4:0] FUNCT_WRITE       = 5'd2;
  localparam logic [4:0] FUNCT_EXEC        = 5'd3;

endpackage

// File: rtl/laa_poll_timer.sv
// Poll-phase cycle counter for the dispatcher.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart count at 0 (priority over enable)
//   enable   : count one poll cycle
//   tc       : count has reached TIMEOUT_CYC-1
module laa_poll_timer #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CW          = $clog2(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/laa_dispatch.sv
// Core-side dispatcher for custom-0 LAA instructions.
//   ins_valid/ins/ins_ready : instruction acceptance from ID (accepted in IDLE)
//   rs1_addr/rs1_data       : core regfile read of ins[31:27]
//   busy                    : pipeline stall while a transaction is in flight
//   wb_valid/wb_rd/wb_data  : one-cycle write-back strobe for READ
//   laa_req/op/addr/wdata   : request toward the accelerator, held until laa_ack
//   laa_ack/laa_rdata       : accelerator completion and read data
//   illegal/timeout         : one-cycle event pulses
module laa_dispatch
  import laa_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int LAA_ADDR_W  = 5,
  parameter int STATUS_ADDR = 2**LAA_ADDR_W - 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  ins_valid,
  input  logic [31:0]           ins,
  output logic                  ins_ready,
  output logic [4:0]            rs1_addr,
  input  logic [XLEN-1:0]       rs1_data,
  output logic                  busy,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  laa_req,
  output laa_opcode_t           laa_op,
  output logic [LAA_ADDR_W-1:0] laa_addr,
  output logic [XLEN-1:0]       laa_wdata,
  input  logic                  laa_ack,
  input  logic [XLEN-1:0]       laa_rdata,
  output logic                  illegal,
  output logic                  timeout
);

  disp_state_t state;
  logic [4:0]  funct;
  logic        op_ok;
  logic        hit;        // accelerator completed the pending request
  logic        poll_clr;
  logic        poll_tc;
  logic        unused_ins;

  assign funct      = ins[11:7];
  assign op_ok      = (ins[6:0] == LAA_CUSTOM_OPCODE);
  assign rs1_addr   = ins[31:27];
  assign ins_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign hit        = laa_req & laa_ack;
  assign unused_ins = ^ins[21:12];

  // Poll count restarts on the MULTIPLY ack that moves us into POLL.
  assign poll_clr = (state == ST_ISSUE) && hit && (laa_op == LAA_MULTIPLY);

  laa_poll_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (Rst),
    .clear  (poll_clr),
    .enable (state == ST_POLL),
    .tc     (poll_tc)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      laa_req   <= 1'b0;
      laa_op    <= LAA_NONE;
      laa_addr  <= '0;
      laa_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ins_valid) begin
            if (!op_ok) begin
              illegal <= 1'b1;
            end else begin
              case (funct)
                FUNCT_WRITE: begin
                  laa_addr  <= LAA_ADDR_W'(ins[26:22]);
                  laa_wdata <= rs1_data;
                  laa_op    <= LAA_WRITE;
                  laa_req   <= 1'b1;
                  state     <= ST_ISSUE;
                end
                FUNCT_READ: begin
                  laa_addr <= LAA_ADDR_W'(ins[31:27]);
                  wb_rd    <= ins[26:22];
                  laa_op   <= LAA_READ;
                  laa_req  <= 1'b1;
                  state    <= ST_ISSUE;
                end
                FUNCT_EXEC: begin
                  laa_op  <= LAA_MULTIPLY;
                  laa_req <= 1'b1;
                  state   <= ST_ISSUE;
                end
                default: illegal <= 1'b1;
              endcase
            end
          end
        end
        ST_ISSUE: begin
          if (hit) begin
            laa_req <= 1'b0;
            case (laa_op)
              LAA_READ: begin
                wb_data  <= laa_rdata;
                wb_valid <= (wb_rd != 5'd0);  // x0 target: transaction only
                state    <= ST_WB;
              end
              LAA_MULTIPLY: begin
                // Request drops for one cycle, then status reads begin.
                laa_op   <= LAA_READ;
                laa_addr <= LAA_ADDR_W'(STATUS_ADDR);
                state    <= ST_POLL;
              end
              default: begin
                laa_op <= LAA_NONE;
                state  <= ST_IDLE;
              end
            endcase
          end
        end
        ST_POLL: begin
          if (hit && (laa_rdata != '0)) begin
            // Completion beats a simultaneous terminal count.
            laa_req <= 1'b0;
            laa_op  <= LAA_NONE;
            state   <= ST_IDLE;
          end else if (poll_tc) begin
            laa_req <= 1'b0;
            laa_op  <= LAA_NONE;
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            // One idle cycle after every ack so an ack is never reused.
            laa_req <= ~hit;
          end
        end
        ST_WB: begin
          laa_op <= LAA_NONE;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laa_dispatch.sv
// Directed bench for laa_dispatch with a small accelerator responder.
module tb_laa_dispatch;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            Rst = 1'b1;
  logic            ins_valid = 1'b0;
  logic [31:0]     ins = '0;
  logic            ins_ready;
  logic [4:0]      rs1_addr;
  logic [XLEN-1:0] rs1_data = '0;
  logic            busy;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            laa_req;
  logic [1:0]      laa_op;
  logic [AW-1:0]   laa_addr;
  logic [XLEN-1:0] laa_wdata;
  logic            laa_ack = 1'b0;
  logic [XLEN-1:0] laa_rdata = '0;
  logic            illegal;
  logic            timeout;

  laa_dispatch #(.XLEN(XLEN), .LAA_ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .Rst(Rst), .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .laa_req(laa_req), .laa_op(laa_op),
    .laa_addr(laa_addr), .laa_wdata(laa_wdata), .laa_ack(laa_ack),
    .laa_rdata(laa_rdata), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responder / monitor state
  int              ack_delay = 0;
  logic [XLEN-1:0] read_val  = '0;
  logic [XLEN-1:0] status_q[$];
  int age = 0;
  int req_cyc = 0, wr_req_cyc = 0, poll_cyc = 0;
  int n_wr = 0, n_rd = 0, n_rd31 = 0, n_mul = 0;
  int wb_cnt = 0, ill_cnt = 0, to_cnt = 0;
  logic [AW-1:0]   wr_addr_l = '0;
  logic [XLEN-1:0] wr_data_l = '0;
  logic [4:0]      wb_rd_l = '0;
  logic [XLEN-1:0] wb_data_l = '0;
  logic            to_busy = 1'b1;

  always @(negedge clk) begin
    if (Rst || !laa_req) begin
      laa_ack = 1'b0;
      age = 0;
    end else if (age == ack_delay) begin
      laa_ack = 1'b1;
      age = 0;
      case (laa_op)
        2'd1: begin
          n_rd++;
          if (laa_addr == 5'd31) begin
            n_rd31++;
            if (status_q.size() > 0) laa_rdata = status_q.pop_front();
            else laa_rdata = '0;
          end else laa_rdata = read_val;
        end
        2'd2: begin n_wr++; wr_addr_l = laa_addr; wr_data_l = laa_wdata; end
        2'd3: n_mul++;
        default: ;
      endcase
    end else begin
      laa_ack = 1'b0;
      age++;
    end
    if (laa_req) req_cyc++;
    if (laa_req && laa_op == 2'd2) wr_req_cyc++;
    if (busy && laa_op == 2'd1 && laa_addr == 5'd31) poll_cyc++;
    if (wb_valid) begin wb_cnt++; wb_rd_l = wb_rd; wb_data_l = wb_data; end
    if (illegal) ill_cnt++;
    if (timeout) begin to_cnt++; to_busy = busy; end
  end

  function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] f, input logic [6:0] op);
    return {a, b, 10'b0, f, op};
  endfunction

  // Presents one instruction for one cycle; returns in the cycle after acceptance.
  task automatic present(input logic [31:0] i, input logic [XLEN-1:0] d);
    logic [31:0] iv;
    iv = i;
    @(negedge clk); #1;
    ins_valid = 1'b1; ins = iv; rs1_data = d;
    #1 chk("rs1_addr", rs1_addr, iv[31:27]);
    @(negedge clk); #1;
    ins_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (!ins_ready && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    chk("idle_wait", ins_ready, 1);
  endtask

  localparam logic [6:0] OPC = 7'b0001011;

  int s_req, s_wrc, s_wr, s_rd31, s_mul, s_wb, s_ill, s_to, s_poll, s_rd;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    #1 Rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_req", laa_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ins_ready, 1);
    chk("rst_op", laa_op, 0);
    chk("rst_addr", laa_addr, 0);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
    chk("rst_pulse", {illegal, timeout}, 0);

    // WRITE, ack on third request cycle
    ack_delay = 2;
    s_req = req_cyc; s_wrc = wr_req_cyc; s_wr = n_wr; s_wb = wb_cnt;
    present(mk(5'd5, 5'd7, 5'd2, OPC), 32'hDEADBEEF);
    chk("wr_req", laa_req, 1);
    chk("wr_op", laa_op, 2);
    chk("wr_addr", laa_addr, 7);
    chk("wr_wdata", laa_wdata, 32'hDEADBEEF);
    chk("wr_busy", {busy, ins_ready}, 2'b10);
    wait_idle(20);
    chk("wr_req_cycles", wr_req_cyc - s_wrc, 3);
    chk("wr_req_total", req_cyc - s_req, 3);
    chk("wr_txn", n_wr - s_wr, 1);
    chk("wr_addr_ack", wr_addr_l, 7);
    chk("wr_data_ack", wr_data_l, 32'hDEADBEEF);
    chk("wr_no_wb", wb_cnt - s_wb, 0);

    // READ, immediate ack, cycle-exact
    ack_delay = 0; read_val = 32'h12345678;
    s_wb = wb_cnt;
    present(mk(5'd4, 5'd10, 5'd1, OPC), 32'h0);
    chk("rd_req", laa_req, 1);
    chk("rd_op", laa_op, 1);
    chk("rd_addr", laa_addr, 4);
    @(negedge clk); #1;
    chk("rd_wbv", wb_valid, 1);
    chk("rd_wbrd", wb_rd, 10);
    chk("rd_wbdata", wb_data, 32'h12345678);
    chk("rd_req_drop", laa_req, 0);
    chk("rd_ready_wb", ins_ready, 0);
    @(negedge clk); #1;
    chk("rd_wbv_end", wb_valid, 0);
    chk("rd_ready", ins_ready, 1);
    chk("rd_wb_once", wb_cnt - s_wb, 1);

    // READ to x0: transaction happens, no write-back
    read_val = 32'hCAFE0001;
    s_wb = wb_cnt; s_rd = n_rd;
    present(mk(5'd4, 5'd0, 5'd1, OPC), 32'h0);
    wait_idle(20);
    chk("rd0_txn", n_rd - s_rd, 1);
    chk("rd0_no_wb", wb_cnt - s_wb, 0);

    // EXECUTE, status 0,0,1
    status_q = '{32'h0, 32'h0, 32'h1};
    s_mul = n_mul; s_rd31 = n_rd31; s_to = to_cnt;
    present(mk(5'd1, 5'd2, 5'd3, OPC), 32'h0);
    chk("ex_op", laa_op, 3);
    wait_idle(60);
    chk("ex_mul", n_mul - s_mul, 1);
    chk("ex_polls", n_rd31 - s_rd31, 3);
    chk("ex_no_to", to_cnt - s_to, 0);
    chk("ex_idle_op", laa_op, 0);

    // EXECUTE, status never set -> timeout
    status_q.delete();
    s_to = to_cnt; s_poll = poll_cyc;
    present(mk(5'd1, 5'd2, 5'd3, OPC), 32'h0);
    wait_idle(100);
    chk("to_pulse", to_cnt - s_to, 1);
    chk("to_poll_cycles", poll_cyc - s_poll, TO);
    chk("to_busy_low", to_busy, 0);
    chk("to_req_low", laa_req, 0);

    // Illegal instructions
    s_req = req_cyc; s_ill = ill_cnt;
    present(mk(5'd1, 5'd2, 5'd2, 7'b0110011), 32'h0);
    chk("ill_op_pulse", illegal, 1);
    chk("ill_op_ready", {ins_ready, busy}, 2'b10);
    present(mk(5'd1, 5'd2, 5'd7, OPC), 32'h0);
    chk("ill_f7_pulse", illegal, 1);
    chk("ill_f7_ready", {ins_ready, busy}, 2'b10);
    present(mk(5'd1, 5'd2, 5'd0, OPC), 32'h0);
    chk("ill_f0_pulse", illegal, 1);
    @(negedge clk); #1;
    chk("ill_clear", illegal, 0);
    chk("ill_count", ill_cnt - s_ill, 3);
    chk("ill_no_req", req_cyc - s_req, 0);

    // Reset during POLL
    s_to = to_cnt; s_wb = wb_cnt;
    present(mk(5'd1, 5'd2, 5'd3, OPC), 32'h0);
    repeat (4) begin @(negedge clk); #1; end
    chk("rp_in_poll", {busy, laa_op, laa_addr}, {1'b1, 2'd1, 5'd31});
    Rst = 1'b1;
    @(negedge clk); #1;
    Rst = 1'b0;
    chk("rp_req", laa_req, 0);
    chk("rp_busy", busy, 0);
    repeat (25) begin @(negedge clk); #1; end
    chk("rp_no_to", to_cnt - s_to, 0);
    chk("rp_no_wb", wb_cnt - s_wb, 0);
    read_val = 32'hA5A50001;
    present(mk(5'd9, 5'd3, 5'd1, OPC), 32'h0);
    wait_idle(20);
    chk("rp_rd_wb", wb_cnt - s_wb, 1);
    chk("rp_rd_rd", wb_rd_l, 3);
    chk("rp_rd_data", wb_data_l, 32'hA5A50001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/laa_dispatch.md
Name: laa_dispatch

Overview:
Parametrised successor to the core-side LAA interface: decodes custom-0 instructions (opcode 7'b0001011) and sequences WRITE, READ and EXECUTE transactions to the linear-algebra accelerator over a req/ack handshake. Adds decoupled instruction acceptance, write-back handshaking to the core register file, status polling after EXECUTE with a bounded timeout, and explicit illegal-instruction reporting. Sits between the ID stage (instruction, rs1 data) and the LAA register file / compute unit.

Parameters:
XLEN, 32, data width of core registers and LAA registers
LAA_ADDR_W, 5, LAA register address width (2**LAA_ADDR_W registers)
STATUS_ADDR, 2**LAA_ADDR_W-1, LAA register polled for completion (nonzero = done)
TIMEOUT_CYC, 1024, maximum cycles spent in POLL before abort; must be >= 2

Ports:
clk  in  1  system clock
Rst  in  1  synchronous active-high reset
ins_valid  in  1  instruction presented
ins  in  32  instruction word
ins_ready  out  1  dispatcher can accept (state==IDLE)
rs1_addr  out  5  ins[31:27], combinational, to core regfile read port
rs1_data  in  XLEN  core register data for rs1_addr
busy  out  1  state != IDLE (stalls core pipeline)
wb_valid  out  1  one-cycle write-back strobe
wb_rd  out  5  core destination register
wb_data  out  XLEN  write-back data
laa_req  out  1  LAA transaction request
laa_op  out  2  laa_opcode_t (NONE/READ/WRITE/MULTIPLY)
laa_addr  out  LAA_ADDR_W  LAA register address
laa_wdata  out  XLEN  LAA write data
laa_ack  in  1  LAA completed transaction this cycle
laa_rdata  in  XLEN  LAA read data, valid with laa_ack
illegal  out  1  one-cycle pulse: rejected instruction
timeout  out  1  one-cycle pulse: EXECUTE poll timed out

Behaviour:
- Reset: state IDLE; laa_req, wb_valid, illegal, timeout, busy = 0; laa_op = NONE; laa_addr, laa_wdata, wb_rd, wb_data = 0; poll counter = 0. Reset mid-transaction aborts it with no write-back and no pulse.
- Accept on ins_valid & ins_ready at a rising edge. Decode funct = ins[11:7].
- Illegal: ins[6:0] != 7'b0001011 or funct not in {1,2,3}. Instruction consumed, illegal=1 next cycle, state stays IDLE, no LAA activity.
- WRITE (funct 2): capture laa_addr=ins[26:22], laa_wdata=rs1_data -> ISSUE. laa_req=1, laa_op=WRITE held stable until the cycle laa_ack=1; next edge -> IDLE. No write-back.
- READ (funct 1): laa_addr=ins[31:27], wb_rd=ins[26:22] -> ISSUE with laa_op=READ. On ack capture laa_rdata -> WB: wb_valid=1 one cycle with wb_data -> IDLE. wb_rd==0: transaction still performed, wb_valid suppressed.
- EXECUTE (funct 3): ISSUE laa_op=MULTIPLY until ack -> POLL: laa_req=1, laa_op=READ, laa_addr=STATUS_ADDR. On ack with laa_rdata != 0 -> IDLE; ack with 0 -> keep polling. Counter increments every POLL cycle, cleared on POLL entry; reaching TIMEOUT_CYC-1 without done -> timeout=1 next cycle, laa_req dropped, -> IDLE. Done and timeout on the same cycle: done wins, no pulse.
- laa_ack outside laa_req is ignored. laa_req deasserts the cycle after ack (no back-to-back reuse of ack).
- Minimum latency (ack in first req cycle): WRITE 2 cycles accept-to-ready; READ wb_valid 2 cycles after accept edge; ins_ready high again the cycle after wb_valid.
- States: IDLE, ISSUE, POLL, WB. busy and ins_ready are mutually exclusive.

Decomposition:
- Package laa_pkg: laa_opcode_t {NONE=0, READ=1, WRITE=2, MULTIPLY=3}, LAA_CUSTOM_OPCODE=7'b0001011, FUNCT_READ=5'd1, FUNCT_WRITE=5'd2, FUNCT_EXEC=5'd3, dispatch state enum.
- One sub-module: laa_poll_timer (clear, enable, terminal-count output, width $clog2(TIMEOUT_CYC)).

Test Plan:
- WRITE ins{31:27=5,26:22=7,funct 2}, rs1_data=32'hDEADBEEF, ack after 3 cycles -> laa_req held 3 cycles, laa_op=WRITE, laa_addr=7, laa_wdata=DEADBEEF, no wb_valid.
- READ ins{31:27=4,26:22=10,funct 1}, ack immediate with rdata=32'h12345678 -> wb_valid one cycle, wb_rd=10, wb_data=12345678; repeat with rd=0 -> no wb_valid.
- EXECUTE, status reads 0,0,then 1 -> MULTIPLY issued once, three READs of addr 31, return to IDLE, no timeout.
- EXECUTE with status always 0, TIMEOUT_CYC=16 -> timeout pulse exactly once after 16 poll cycles, busy falls same cycle.
- ins[6:0]=7'b0110011 and funct=5'd7 variants -> illegal pulse, laa_req never asserts, ins_ready stays 1.
- Rst asserted during POLL -> next cycle laa_req=0, busy=0, no timeout or wb_valid; subsequent READ works normally.
